// File: rtl/ctrl_pipeline.sv
// ctrl_pipeline: carries the decoded control word and register indices of the
// 5-stage RV32I core from ID through the ID/EX, EX/MEM and MEM/WB registers.
// It inserts bubbles for load-use hazards and EX redirects, freezes the whole
// pipeline while data memory is busy, and selects the EX operand forwarding
// sources.
//
// Ports
//   clk, rst_n                      rising-edge clock, async active-low reset
//   id_valid/id_ctrl/id_rs1/2/id_rd decoded instruction in ID
//     id_ctrl = {Jump,Branch,MemRead,MemtoReg,ALUOp[2:0],MemWrite,ALUSrc,
//                RegWrite,R,rdsel[1:0]} (bits 12..0)
//   ex_redirect                     EX resolved a taken branch/jump
//   mem_busy                        data memory not ready
//   ex_valid/ex_ctrl/ex_rs1/2/ex_rd ID/EX register
//   mem_valid/mem_ctrl/mem_rd       EX/MEM register
//   wb_valid/wb_ctrl/wb_rd          MEM/WB register
//   fwd_a/fwd_b                     00 regfile, 01 EX/MEM, 10 MEM/WB
//   stall_if                        hold PC and IF/ID
//   flush_id                        kill IF/ID contents
//   stall_cnt                       saturating count of stalled cycles
module ctrl_pipeline #(
  parameter int unsigned RA_W   = 5,
  parameter int unsigned CTRL_W = 13,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic [RA_W-1:0]   id_rs1,
  input  logic [RA_W-1:0]   id_rs2,
  input  logic [RA_W-1:0]   id_rd,
  input  logic              ex_redirect,
  input  logic              mem_busy,
  output logic              ex_valid,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [RA_W-1:0]   ex_rs1,
  output logic [RA_W-1:0]   ex_rs2,
  output logic [RA_W-1:0]   ex_rd,
  output logic              mem_valid,
  output logic [CTRL_W-1:0] mem_ctrl,
  output logic [RA_W-1:0]   mem_rd,
  output logic              wb_valid,
  output logic [CTRL_W-1:0] wb_ctrl,
  output logic [RA_W-1:0]   wb_rd,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b,
  output logic              stall_if,
  output logic              flush_id,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam int unsigned C_MEMREAD  = 10;
  localparam int unsigned C_REGWRITE = 3;

  typedef enum logic [1:0] {
    ACT_ADVANCE,
    ACT_HOLD,
    ACT_REDIRECT,
    ACT_LOADUSE
  } act_e;

  logic              r_ex_valid, r_mem_valid, r_wb_valid;
  logic [CTRL_W-1:0] r_ex_ctrl, r_mem_ctrl, r_wb_ctrl;
  logic [RA_W-1:0]   r_ex_rs1, r_ex_rs2, r_ex_rd, r_mem_rd, r_wb_rd;
  logic [CNT_W-1:0]  r_stall_cnt;

  logic              w_load_use;
  act_e              w_act;
  logic              w_stall_if, w_flush_id;
  logic [1:0]        w_fwd_a, w_fwd_b;

  // rs2 is compared even for instructions that do not read it.
  always_comb begin
    w_load_use = id_valid && r_ex_valid && r_ex_ctrl[C_MEMREAD] &&
                 (r_ex_rd != '0) && ((r_ex_rd == id_rs1) || (r_ex_rd == id_rs2));
  end

  // Redirect outranks load-use: the dependent ID instruction is being killed.
  always_comb begin
    w_act      = ACT_ADVANCE;
    w_stall_if = 1'b0;
    w_flush_id = 1'b0;
    if (mem_busy) begin
      w_act      = ACT_HOLD;
      w_stall_if = 1'b1;
    end else if (ex_redirect) begin
      w_act      = ACT_REDIRECT;
      w_flush_id = 1'b1;
    end else if (w_load_use) begin
      w_act      = ACT_LOADUSE;
      w_stall_if = 1'b1;
    end
  end

  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (r_mem_valid && r_mem_ctrl[C_REGWRITE] && (r_mem_rd != '0) && (r_mem_rd == r_ex_rs1))
      w_fwd_a = 2'b01;
    else if (r_wb_valid && r_wb_ctrl[C_REGWRITE] && (r_wb_rd != '0) && (r_wb_rd == r_ex_rs1))
      w_fwd_a = 2'b10;
    if (r_mem_valid && r_mem_ctrl[C_REGWRITE] && (r_mem_rd != '0) && (r_mem_rd == r_ex_rs2))
      w_fwd_b = 2'b01;
    else if (r_wb_valid && r_wb_ctrl[C_REGWRITE] && (r_wb_rd != '0) && (r_wb_rd == r_ex_rs2))
      w_fwd_b = 2'b10;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ex_valid  <= 1'b0;
      r_ex_ctrl   <= '0;
      r_ex_rs1    <= '0;
      r_ex_rs2    <= '0;
      r_ex_rd     <= '0;
      r_mem_valid <= 1'b0;
      r_mem_ctrl  <= '0;
      r_mem_rd    <= '0;
      r_wb_valid  <= 1'b0;
      r_wb_ctrl   <= '0;
      r_wb_rd     <= '0;
    end else if (w_act != ACT_HOLD) begin
      r_mem_valid <= r_ex_valid;
      r_mem_ctrl  <= r_ex_ctrl;
      r_mem_rd    <= r_ex_rd;
      r_wb_valid  <= r_mem_valid;
      r_wb_ctrl   <= r_mem_ctrl;
      r_wb_rd     <= r_mem_rd;
      if ((w_act == ACT_ADVANCE) && id_valid) begin
        r_ex_valid <= 1'b1;
        r_ex_ctrl  <= id_ctrl;
        r_ex_rs1   <= id_rs1;
        r_ex_rs2   <= id_rs2;
        r_ex_rd    <= id_rd;
      end else begin
        r_ex_valid <= 1'b0;
        r_ex_ctrl  <= '0;
        r_ex_rs1   <= '0;
        r_ex_rs2   <= '0;
        r_ex_rd    <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_stall_cnt <= '0;
    else if (w_stall_if && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 1'b1;
  end

  // A load in EX/MEM is never a legal forwarding source; the load-use stall
  // must have separated it from its consumer.
  a_no_load_fwd: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_mem_valid && r_mem_ctrl[C_MEMREAD] && ((w_fwd_a == 2'b01) || (w_fwd_b == 2'b01))));

  assign ex_valid  = r_ex_valid;
  assign ex_ctrl   = r_ex_ctrl;
  assign ex_rs1    = r_ex_rs1;
  assign ex_rs2    = r_ex_rs2;
  assign ex_rd     = r_ex_rd;
  assign mem_valid = r_mem_valid;
  assign mem_ctrl  = r_mem_ctrl;
  assign mem_rd    = r_mem_rd;
  assign wb_valid  = r_wb_valid;
  assign wb_ctrl   = r_wb_ctrl;
  assign wb_rd     = r_wb_rd;
  assign fwd_a     = w_fwd_a;
  assign fwd_b     = w_fwd_b;
  assign stall_if  = w_stall_if;
  assign flush_id  = w_flush_id;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// tb_ctrl_pipeline: directed bench for ctrl_pipeline.
module tb_ctrl_pipeline;

  localparam int unsigned RA_W   = 5;
  localparam int unsigned CTRL_W = 13;
  localparam int unsigned CNT_W  = 16;

  // {Jump,Branch,MemRead,MemtoReg,ALUOp[2:0],MemWrite,ALUSrc,RegWrite,R,rdsel}
  localparam logic [CTRL_W-1:0] C_LW  = 13'h0618; // MemRead,MemtoReg,ALUSrc,RegWrite
  localparam logic [CTRL_W-1:0] C_ADD = 13'h008C; // ALUOp=010,RegWrite,R
  localparam logic [CTRL_W-1:0] C_SUB = 13'h00CC; // ALUOp=011,RegWrite,R

  logic              clk = 1'b0;
  logic              rst_n;
  logic              id_valid;
  logic [CTRL_W-1:0] id_ctrl;
  logic [RA_W-1:0]   id_rs1, id_rs2, id_rd;
  logic              ex_redirect, mem_busy;
  logic              ex_valid, mem_valid, wb_valid;
  logic [CTRL_W-1:0] ex_ctrl, mem_ctrl, wb_ctrl;
  logic [RA_W-1:0]   ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic [1:0]        fwd_a, fwd_b;
  logic              stall_if, flush_id;
  logic [CNT_W-1:0]  stall_cnt;

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  ctrl_pipeline #(.RA_W(RA_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_valid(id_valid), .id_ctrl(id_ctrl), .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
    .ex_redirect(ex_redirect), .mem_busy(mem_busy),
    .ex_valid(ex_valid), .ex_ctrl(ex_ctrl), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
    .mem_valid(mem_valid), .mem_ctrl(mem_ctrl), .mem_rd(mem_rd),
    .wb_valid(wb_valid), .wb_ctrl(wb_ctrl), .wb_rd(wb_rd),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_if(stall_if), .flush_id(flush_id),
    .stall_cnt(stall_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic v, input logic [CTRL_W-1:0] c,
                        input logic [RA_W-1:0] rs1, input logic [RA_W-1:0] rs2,
                        input logic [RA_W-1:0] rd);
    id_valid = v;
    id_ctrl  = c;
    id_rs1   = rs1;
    id_rs2   = rs2;
    id_rd    = rd;
  endtask

  initial begin
    rst_n = 1'b0;
    ex_redirect = 1'b0;
    mem_busy = 1'b0;
    set_id(1'b0, '0, '0, '0, '0);
    #1;
    chk("rst_ex_valid", 32'(ex_valid), 32'd0);
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_cnt", 32'(stall_cnt), 32'd0);
    #2 rst_n = 1'b1;

    // 1: reset mid-stream with EX and MEM occupied and a nonzero counter
    mem_busy = 1'b1;
    tick();
    chk("t1_cnt_busy", 32'(stall_cnt), 32'd1);
    mem_busy = 1'b0;
    set_id(1'b1, C_ADD, 5'd1, 5'd2, 5'd1);
    tick();
    set_id(1'b1, C_ADD, 5'd1, 5'd2, 5'd2);
    tick();
    set_id(1'b0, '0, '0, '0, '0);
    chk("t1_pre_ex_valid", 32'(ex_valid), 32'd1);
    chk("t1_pre_mem_valid", 32'(mem_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("t1_ex_valid", 32'(ex_valid), 32'd0);
    chk("t1_mem_valid", 32'(mem_valid), 32'd0);
    chk("t1_ex_ctrl", 32'(ex_ctrl), 32'd0);
    chk("t1_mem_ctrl", 32'(mem_ctrl), 32'd0);
    chk("t1_ex_rd", 32'(ex_rd), 32'd0);
    chk("t1_cnt", 32'(stall_cnt), 32'd0);
    #1 rst_n = 1'b1;

    // 2: lw x5 then add x7,x5,x6
    set_id(1'b1, C_LW, 5'd1, 5'd2, 5'd5);
    tick();
    set_id(1'b1, C_ADD, 5'd5, 5'd6, 5'd7);
    #1;
    chk("t2_stall", 32'(stall_if), 32'd1);
    chk("t2_flush", 32'(flush_id), 32'd0);
    tick();
    chk("t2_ex_bubble", 32'(ex_valid), 32'd0);
    chk("t2_ex_ctrl_bubble", 32'(ex_ctrl), 32'd0);
    chk("t2_mem_rd", 32'(mem_rd), 32'd5);
    chk("t2_cnt", 32'(stall_cnt), 32'd1);
    chk("t2_stall_clear", 32'(stall_if), 32'd0);
    tick();
    set_id(1'b0, '0, '0, '0, '0);
    chk("t2_ex_ctrl", 32'(ex_ctrl), 32'(C_ADD));
    chk("t2_ex_rs1", 32'(ex_rs1), 32'd5);
    chk("t2_wb_rd", 32'(wb_rd), 32'd5);
    chk("t2_fwd_a", 32'(fwd_a), 32'd2);
    chk("t2_fwd_b", 32'(fwd_b), 32'd0);
    chk("t2_cnt_after", 32'(stall_cnt), 32'd1);

    // 3: add x3; add x3,x3,x4; sub x9,x8,x3
    set_id(1'b1, C_ADD, 5'd1, 5'd2, 5'd3);
    tick();
    set_id(1'b1, C_ADD, 5'd3, 5'd4, 5'd3);
    tick();
    chk("t3_fwd_a_mid", 32'(fwd_a), 32'd1);
    set_id(1'b1, C_SUB, 5'd8, 5'd3, 5'd9);
    #1;
    chk("t3_no_stall", 32'(stall_if), 32'd0);
    tick();
    set_id(1'b0, '0, '0, '0, '0);
    chk("t3_ex_ctrl", 32'(ex_ctrl), 32'(C_SUB));
    chk("t3_fwd_b", 32'(fwd_b), 32'd1);
    chk("t3_fwd_a", 32'(fwd_a), 32'd0);
    chk("t3_cnt", 32'(stall_cnt), 32'd1);
    tick();
    tick();
    tick();

    // 4: redirect coinciding with a load-use hazard
    set_id(1'b1, C_LW, 5'd1, 5'd2, 5'd5);
    tick();
    set_id(1'b1, C_ADD, 5'd5, 5'd6, 5'd7);
    ex_redirect = 1'b1;
    #1;
    chk("t4_flush", 32'(flush_id), 32'd1);
    chk("t4_stall", 32'(stall_if), 32'd0);
    tick();
    ex_redirect = 1'b0;
    set_id(1'b0, '0, '0, '0, '0);
    chk("t4_ex_bubble", 32'(ex_valid), 32'd0);
    chk("t4_mem_ctrl", 32'(mem_ctrl), 32'(C_LW));
    chk("t4_cnt", 32'(stall_cnt), 32'd1);

    // 5: three busy cycles freeze everything
    set_id(1'b1, C_ADD, 5'd1, 5'd2, 5'd10);
    tick();
    set_id(1'b1, C_ADD, 5'd1, 5'd2, 5'd11);
    tick();
    set_id(1'b1, C_ADD, 5'd1, 5'd2, 5'd12);
    tick();
    set_id(1'b1, C_ADD, 5'd1, 5'd2, 5'd13);
    mem_busy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t5_stall", 32'(stall_if), 32'd1);
      tick();
      chk("t5_ex_rd", 32'(ex_rd), 32'd12);
      chk("t5_mem_rd", 32'(mem_rd), 32'd11);
      chk("t5_wb_rd", 32'(wb_rd), 32'd10);
    end
    chk("t5_cnt", 32'(stall_cnt), 32'd4);
    mem_busy = 1'b0;
    #1;
    chk("t5_release", 32'(stall_if), 32'd0);
    tick();
    set_id(1'b0, '0, '0, '0, '0);
    chk("t5_adv_ex", 32'(ex_rd), 32'd13);
    chk("t5_adv_mem", 32'(mem_rd), 32'd12);
    chk("t5_adv_wb", 32'(wb_rd), 32'd11);
    chk("t5_cnt_after", 32'(stall_cnt), 32'd4);
    tick();
    tick();
    tick();

    // 6: load to x0 then use of x0; counter saturation
    set_id(1'b1, C_LW, 5'd1, 5'd2, 5'd0);
    tick();
    set_id(1'b1, C_ADD, 5'd0, 5'd0, 5'd6);
    #1;
    chk("t6_no_stall", 32'(stall_if), 32'd0);
    tick();
    set_id(1'b0, '0, '0, '0, '0);
    chk("t6_ex_valid", 32'(ex_valid), 32'd1);
    chk("t6_fwd_a", 32'(fwd_a), 32'd0);
    chk("t6_fwd_b", 32'(fwd_b), 32'd0);
    chk("t6_cnt", 32'(stall_cnt), 32'd4);
    mem_busy = 1'b1;
    for (int i = 0; i < 65530; i++) @(posedge clk);
    #1;
    chk("t6_cnt_fffe", 32'(stall_cnt), 32'hFFFE);
    tick();
    chk("t6_cnt_ffff", 32'(stall_cnt), 32'hFFFF);
    tick();
    chk("t6_cnt_sat", 32'(stall_cnt), 32'hFFFF);
    tick();
    chk("t6_cnt_sat2", 32'(stall_cnt), 32'hFFFF);
    mem_busy = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
